// File: rtl/simd_unpack_v4.sv
// Unpacks a 48-bit word of four 12-bit lane slots into one lane per beat,
// lane 0 first, with a per-lane sign-overflow flag for the narrowed payload.
module simd_unpack_v4 #(
  parameter int width = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             out_ovf
);

  if (width < 1 || width > 12) begin : g_bad_width
    $error("simd_unpack_v4: width must be in 1..12");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] hold_q, hold_d;
  logic [1:0]  lane_q, lane_d;

  logic        in_xfer;
  logic        out_xfer;
  logic [11:0] slot;
  logic        slot_ovf;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
    end
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // NOTE: every signal gets a default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          hold_d  = in_data;
          lane_d  = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (lane_q != 2'd3) begin
            lane_d = lane_q + 2'd1;
          end else if (in_xfer) begin
            hold_d = in_data;
            lane_d = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (lane_q)
      2'd0:    slot = hold_q[11:0];
      2'd1:    slot = hold_q[23:12];
      2'd2:    slot = hold_q[35:24];
      default: slot = hold_q[47:36];
    endcase
  end

  // Bits above the payload must all replicate the payload's top bit.
  always_comb begin
    slot_ovf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i >= width) slot_ovf = slot_ovf | (slot[i] ^ slot[width-1]);
    end
  end

  // Output decode; the ready pass-through lets a new word load on lane 3.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_lane  = '0;
    out_last  = 1'b0;
    out_ovf   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: in_ready = 1'b1;
        SEND: begin
          in_ready  = (lane_q == 2'd3) && out_ready;
          out_valid = 1'b1;
          out_data  = slot[width-1:0];
          out_lane  = lane_q;
          out_last  = (lane_q == 2'd3);
          out_ovf   = slot_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_unpack_v4.sv
// Directed bench for simd_unpack_v4: a 12-bit-lane instance for sequencing,
// stalls and reset, and an 8-bit-lane instance for overflow flagging.
module tb_simd_unpack_v4;

  logic        clock = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_ovf;
  logic [47:0] in_data;
  logic [11:0] out_data;
  logic [1:0]  out_lane;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_ovf8;
  logic [47:0] in_data8;
  logic [7:0]  out_data8;
  logic [1:0]  out_lane8;

  int n_cmp = 0;
  int n_err = 0;

  simd_unpack_v4 #(.width(12)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .out_ovf(out_ovf)
  );

  simd_unpack_v4 #(.width(8)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_lane(out_lane8), .out_last(out_last8), .out_ovf(out_ovf8)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic vld, input logic [11:0] data,
                            input logic [1:0] lane, input logic ovf, input logic rdy);
    check({tag, ".valid"}, 48'(out_valid), 48'(vld));
    check({tag, ".data"},  48'(out_data),  48'(data));
    check({tag, ".lane"},  48'(out_lane),  48'(lane));
    check({tag, ".last"},  48'(out_last),  48'(vld && lane == 2'd3));
    check({tag, ".ovf"},   48'(out_ovf),   48'(ovf));
    check({tag, ".ready"}, 48'(in_ready),  48'(rdy));
  endtask

  logic [47:0] w1, w2, w3, w4, w5;
  logic [11:0] exp_lane [0:3];
  logic [7:0]  exp8_data [0:3];
  logic        exp8_ovf [0:3];

  initial begin
    w1 = 48'hABC_123_456_789;
    w2 = 48'h111_222_333_444;
    w3 = 48'hDEF_CBA_987_654;
    w4 = 48'h0AA_0BB_0CC_0DD;
    w5 = 48'h5A5_A5A_FFF_001;

    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;

    // Reset state: everything quiet, not even in_ready.
    #3;
    check_beat("reset", 1'b0, 12'h000, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = w1;
    #10;
    reset = 1'b0;
    #1;
    check("post_reset.ready", 48'(in_ready), 48'd1);

    // Single word, one lane per cycle.
    exp_lane[0] = 12'h789; exp_lane[1] = 12'h456;
    exp_lane[2] = 12'h123; exp_lane[3] = 12'hABC;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_beat($sformatf("w1.l%0d", i), 1'b1, exp_lane[i], 2'(i), 1'b0, i == 3);
      step();
    end
    check_beat("w1.idle", 1'b0, 12'h000, 2'd0, 1'b0, 1'b1);

    // Back-to-back words with in_valid held high; w2 waits until lane 3.
    in_valid = 1'b1; in_data = w1;
    step();
    in_data = w2;
    for (int i = 0; i < 8; i++) begin
      logic [47:0] w;
      w = (i < 4) ? w1 : w2;
      check_beat($sformatf("b2b.l%0d", i), 1'b1, w[12*(i%4) +: 12], 2'(i % 4), 1'b0, (i % 4) == 3);
      if (i == 7) in_valid = 1'b0;
      step();
    end
    check_beat("b2b.idle", 1'b0, 12'h000, 2'd0, 1'b0, 1'b1);

    // Stall on lane 2 for five cycles while in_valid toggles with junk data.
    in_valid = 1'b1; in_data = w3;
    step();
    in_valid = 1'b0;
    check_beat("stall.l0", 1'b1, 12'h654, 2'd0, 1'b0, 1'b0);
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_beat($sformatf("stall.hold%0d", i), 1'b1, 12'hCBA, 2'd2, 1'b0, 1'b0);
      in_valid = ~in_valid; in_data = 48'hFFF_FFF_FFF_FFF;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check_beat("stall.l2_release", 1'b1, 12'hCBA, 2'd2, 1'b0, 1'b0);
    step();
    check_beat("stall.l3", 1'b1, 12'hDEF, 2'd3, 1'b0, 1'b1);
    step();
    check_beat("stall.idle", 1'b0, 12'h000, 2'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-word discards the remaining lanes.
    in_valid = 1'b1; in_data = w4;
    step();
    in_valid = 1'b0;
    step();
    check_beat("rst.l1", 1'b1, 12'h0CC, 2'd1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_beat("rst.async", 1'b0, 12'h000, 2'd0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("rst.release_ready", 48'(in_ready), 48'd1);
    check("rst.release_valid", 48'(out_valid), 48'd0);
    in_valid = 1'b1; in_data = w5;
    step();
    in_valid = 1'b0;
    check_beat("rst.next_l0", 1'b1, 12'h001, 2'd0, 1'b0, 1'b0);
    step();
    check_beat("rst.next_l1", 1'b1, 12'hFFF, 2'd1, 1'b0, 1'b0);
    step(); step(); step();
    check_beat("rst.next_idle", 1'b0, 12'h000, 2'd0, 1'b0, 1'b1);

    // Width 8: payload narrowing and overflow detection.
    exp8_data[0] = 8'h7F; exp8_ovf[0] = 1'b0;
    exp8_data[1] = 8'h80; exp8_ovf[1] = 1'b0;
    exp8_data[2] = 8'h80; exp8_ovf[2] = 1'b1;
    exp8_data[3] = 8'hFF; exp8_ovf[3] = 1'b1;
    in_valid8 = 1'b1; in_data8 = 48'h0FF_080_F80_07F;
    step();
    in_valid8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w8.l%0d.valid", i), 48'(out_valid8), 48'd1);
      check($sformatf("w8.l%0d.data", i),  48'(out_data8),  48'(exp8_data[i]));
      check($sformatf("w8.l%0d.lane", i),  48'(out_lane8),  48'(i));
      check($sformatf("w8.l%0d.last", i),  48'(out_last8),  48'(i == 3));
      check($sformatf("w8.l%0d.ovf", i),   48'(out_ovf8),   48'(exp8_ovf[i]));
      step();
    end
    check("w8.idle.valid", 48'(out_valid8), 48'd0);
    check("w8.idle.data",  48'(out_data8),  48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
